// File: rtl/assoc_wb_cache.sv
// Set-associative write-back, write-allocate cache with true-LRU replacement.
// Hits complete combinationally in IDLE; misses write back a dirty victim, then refill.
module assoc_wb_cache #(
    parameter int LINE_SIZE = 16,
    parameter int NUM_SETS  = 16,
    parameter int NUM_WAYS  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          is_input_valid,
    input  logic [31:0]                   addr,
    input  logic                          mem_rw,
    input  logic [31:0]                   din,
    input  logic [3:0]                    byte_en,
    output logic                          is_ready,
    output logic                          is_output_valid,
    output logic [31:0]                   dout,
    output logic                          is_hit,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic                          mem_req_write,
    output logic [31-$clog2(LINE_SIZE):0] mem_req_addr,
    output logic [8*LINE_SIZE-1:0]        mem_req_data,
    input  logic                          mem_resp_valid,
    input  logic [8*LINE_SIZE-1:0]        mem_resp_data,
    output logic [31:0]                   hit_count,
    output logic [31:0]                   miss_count
);
    localparam int OFF_W  = $clog2(LINE_SIZE);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int LA_W   = 32 - OFF_W;
    localparam int WSEL_W = OFF_W - 2;
    localparam int LINE_W = 8 * LINE_SIZE;
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int AGE_W  = WAY_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL_REQ, FILL_WAIT} state_t;

    state_t state_q, state_d;

    logic [LINE_W-1:0] data_q  [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
    logic              valid_q [NUM_SETS][NUM_WAYS];
    logic              dirty_q [NUM_SETS][NUM_WAYS];
    logic [AGE_W-1:0]  age_q   [NUM_SETS][NUM_WAYS];

    logic              miss_q;
    logic [LA_W-1:0]   miss_line_q;
    logic [WAY_W-1:0]  victim_q;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WSEL_W-1:0] req_wsel;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim_way;
    logic              victim_dirty;
    logic [LINE_W-1:0] hit_line;
    logic [LINE_W-1:0] merged_line;
    logic              miss_detect;
    logic              write_hit;
    logic              wb_done;
    logic              fill_done;
    logic              lru_en;
    logic [IDX_W-1:0]  lru_idx;
    logic [WAY_W-1:0]  lru_way;
    logic              unused_addr_bits;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign req_tag          = addr[31 -: TAG_W];
    assign req_idx          = addr[OFF_W +: IDX_W];
    assign req_wsel         = addr[2 +: WSEL_W];
    assign fill_idx         = miss_line_q[IDX_W-1:0];
    assign fill_tag         = miss_line_q[LA_W-1:IDX_W];
    assign unused_addr_bits = ^addr[1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Oldest way is the default victim; any invalid way (lowest index) takes precedence.
    always_comb begin
        logic [AGE_W-1:0] oldest;
        logic             found;
        oldest     = '0;
        found      = 1'b0;
        victim_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (age_q[req_idx][w] > oldest) begin
                oldest     = age_q[req_idx][w];
                victim_way = WAY_W'(w);
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found && !valid_q[req_idx][w]) begin
                found      = 1'b1;
                victim_way = WAY_W'(w);
            end
        end
    end

    assign victim_dirty = valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way];
    assign hit_line     = data_q[req_idx][hit_way];

    always_comb begin
        merged_line = hit_line;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) merged_line[int'(req_wsel) * 32 + b * 8 +: 8] = din[b * 8 +: 8];
        end
    end

    assign is_ready        = (state_q == IDLE);
    assign is_output_valid = is_ready && is_input_valid && hit;
    assign is_hit          = is_output_valid && !miss_q;
    assign dout            = (is_output_valid && !mem_rw) ? hit_line[int'(req_wsel) * 32 +: 32] : 32'd0;
    assign miss_detect     = is_ready && is_input_valid && !hit;
    assign write_hit       = is_output_valid && mem_rw && (byte_en != 4'b0000);
    assign wb_done         = (state_q == WRITEBACK) && mem_req_ready;
    assign fill_done       = (state_q == FILL_WAIT) && mem_resp_valid;

    always_comb begin
        lru_en  = 1'b0;
        lru_idx = req_idx;
        lru_way = hit_way;
        if (is_output_valid) begin
            lru_en = 1'b1;
        end else if (fill_done) begin
            lru_en  = 1'b1;
            lru_idx = fill_idx;
            lru_way = victim_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        case (state_q)
            IDLE: begin
                if (miss_detect) state_d = victim_dirty ? WRITEBACK : FILL_REQ;
            end
            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = {tag_q[fill_idx][victim_q], fill_idx};
                mem_req_data  = data_q[fill_idx][victim_q];
                if (mem_req_ready) state_d = FILL_REQ;
            end
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = miss_line_q;
                if (mem_req_ready) state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (mem_resp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The miss request is captured so a refill can finish even if the CPU withdraws it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            miss_q      <= 1'b0;
            miss_line_q <= '0;
            victim_q    <= '0;
            hit_count   <= 32'd0;
            miss_count  <= 32'd0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= AGE_W'(w);
                end
            end
        end else begin
            state_q <= state_d;
            if (miss_detect) begin
                miss_q      <= 1'b1;
                miss_line_q <= addr[31:OFF_W];
                victim_q    <= victim_way;
                miss_count  <= sat_inc(miss_count);
            end else if (is_ready && (is_output_valid || !is_input_valid)) begin
                miss_q <= 1'b0;
            end
            if (is_hit) hit_count <= sat_inc(hit_count);
            if (write_hit) dirty_q[req_idx][hit_way] <= 1'b1;
            if (wb_done) begin
                valid_q[fill_idx][victim_q] <= 1'b0;
                dirty_q[fill_idx][victim_q] <= 1'b0;
            end
            if (fill_done) begin
                valid_q[fill_idx][victim_q] <= 1'b1;
                dirty_q[fill_idx][victim_q] <= 1'b0;
            end
            if (lru_en) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == lru_way)
                        age_q[lru_idx][w] <= '0;
                    else if (age_q[lru_idx][w] < age_q[lru_idx][lru_way])
                        age_q[lru_idx][w] <= age_q[lru_idx][w] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_q[fill_idx][victim_q] <= mem_resp_data;
            tag_q[fill_idx][victim_q]  <= fill_tag;
        end
        if (write_hit) data_q[req_idx][hit_way] <= merged_line;
    end

endmodule

// File: tb/tb_assoc_wb_cache.sv
// Directed bench for assoc_wb_cache (16B lines, 16 sets, 2 ways) with queue-based
// scoreboards for CPU responses and backing-memory requests.
module tb_assoc_wb_cache;
    logic         clk = 1'b0;
    logic         reset;
    logic         is_input_valid;
    logic [31:0]  addr;
    logic         mem_rw;
    logic [31:0]  din;
    logic [3:0]   byte_en;
    logic         is_ready;
    logic         is_output_valid;
    logic [31:0]  dout;
    logic         is_hit;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_write;
    logic [27:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    assoc_wb_cache #(.LINE_SIZE(16), .NUM_SETS(16), .NUM_WAYS(2)) dut (
        .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
        .mem_rw(mem_rw), .din(din), .byte_en(byte_en), .is_ready(is_ready),
        .is_output_valid(is_output_valid), .dout(dout), .is_hit(is_hit),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic hit; logic [31:0] dout; } out_exp_t;
    typedef struct { logic write; logic [27:0] la; logic [127:0] data; } mem_exp_t;

    out_exp_t     out_q[$];
    mem_exp_t     mem_q[$];
    logic [127:0] mem [logic [27:0]];

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int accepted = 0;
    int stall_left = 0;
    bit hold_resp = 0;
    bit resp_pending = 0;
    logic [27:0] resp_line;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input logic [27:0] la);
        logic [127:0] l;
        if (mem.exists(la)) return mem[la];
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = 32'hC0DE0000 | ((32'(la) * 4 + w) & 32'hFFFF);
        return l;
    endfunction

    task automatic expect_mem(input logic wr, input logic [27:0] la, input logic [127:0] data);
        mem_exp_t e;
        e.write = wr; e.la = la; e.data = data;
        mem_q.push_back(e);
    endtask

    task automatic do_req(input logic [31:0] a, input logic rw, input logic [31:0] d,
                          input logic [3:0] be, input logic eh, input logic [31:0] ed);
        out_exp_t e;
        int start;
        bit done;
        e.hit = eh; e.dout = ed;
        out_q.push_back(e);
        @(posedge clk); #1;
        addr = a; mem_rw = rw; din = d; byte_en = be; is_input_valid = 1'b1;
        start = done_cnt;
        done  = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk);
            if (done_cnt != start) done = 1;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL req_timeout addr=%0h: got no is_output_valid, required one within 100 cycles", a);
        end
        #1 is_input_valid = 1'b0;
    endtask

    // Response monitor: pops the next expected completion whenever the DUT presents one.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && is_output_valid) begin
                out_exp_t e;
                done_cnt++;
                if (out_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_output addr=%0h: got is_output_valid=1 required 0", addr);
                end else begin
                    e = out_q.pop_front();
                    chk($sformatf("is_hit@%0h", addr), is_hit, e.hit);
                    chk($sformatf("dout@%0h", addr), dout, e.dout);
                end
            end
        end
    end

    // Backing memory: stalls on request, checks handshake stability, answers reads a cycle later.
    initial begin
        bit          seen = 0;
        logic [27:0] first_addr;
        logic        first_write;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (resp_pending && !hold_resp) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = line_of(resp_line);
                resp_pending   = 0;
            end
            mem_req_ready = 1'b0;
            if (reset && mem_req_valid) begin
                if (!seen) begin
                    seen = 1; first_addr = mem_req_addr; first_write = mem_req_write;
                end else begin
                    chk("stall_addr_stable", mem_req_addr, first_addr);
                    chk("stall_write_stable", mem_req_write, first_write);
                end
                if (stall_left > 0) begin
                    stall_left--;
                    chk("stall_is_ready", is_ready, 1'b0);
                end else begin
                    mem_exp_t e;
                    mem_req_ready = 1'b1;
                    seen = 0;
                    accepted++;
                    if (mem_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_mem_req: got line %0h write=%0b required no request", mem_req_addr, mem_req_write);
                    end else begin
                        e = mem_q.pop_front();
                        chk("mem_req_write", mem_req_write, e.write);
                        chk("mem_req_addr", mem_req_addr, e.la);
                        if (e.write) chk("mem_req_data", mem_req_data, e.data);
                    end
                    if (mem_req_write) mem[mem_req_addr] = mem_req_data;
                    else begin resp_pending = 1; resp_line = mem_req_addr; end
                end
            end else if (reset && seen) begin
                chk("stall_valid_stable", mem_req_valid, 1'b1);
                seen = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        reset = 1'b0; is_input_valid = 1'b0; addr = '0; mem_rw = 1'b0; din = '0; byte_en = '0;
        mem[28'h10] = {32'h11, 32'h22, 32'h33, 32'h44};
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("reset_is_ready", is_ready, 1'b1);
        chk("reset_out_valid", is_output_valid, 1'b0);
        chk("reset_mem_req_valid", mem_req_valid, 1'b0);
        chk("reset_counts", {hit_count, miss_count}, 64'd0);

        // Cold miss with a 5-cycle stalled fill request, then a same-cycle hit.
        stall_left = 5;
        expect_mem(0, 28'h10, '0);
        do_req(32'h100, 0, 0, 4'h0, 0, 32'h44);
        do_req(32'h100, 0, 0, 4'h0, 1, 32'h44);
        chk("hit_count_1", hit_count, 32'd1);
        chk("miss_count_1", miss_count, 32'd1);

        // Byte-enable merges on a hit line; all-zero enables leave the word alone.
        do_req(32'h104, 1, 32'h11223344, 4'hF, 1, 32'h0);
        do_req(32'h104, 1, 32'hAABBCCDD, 4'h3, 1, 32'h0);
        do_req(32'h104, 0, 0, 4'h0, 1, 32'h1122CCDD);
        do_req(32'h108, 1, 32'hDEADBEEF, 4'h0, 1, 32'h0);
        do_req(32'h108, 0, 0, 4'h0, 1, 32'h22);

        // Fill the second way of set 0, touch it, then evict dirty LRU line 0x10.
        expect_mem(0, 28'h20, '0);
        do_req(32'h200, 0, 0, 4'h0, 0, 32'hC0DE0080);
        do_req(32'h204, 0, 0, 4'h0, 1, 32'hC0DE0081);
        expect_mem(1, 28'h10, {32'h11, 32'h22, 32'h1122CCDD, 32'h44});
        expect_mem(0, 28'h30, '0);
        do_req(32'h300, 0, 0, 4'h0, 0, 32'hC0DE00C0);
        do_req(32'h200, 0, 0, 4'h0, 1, 32'hC0DE0080);
        expect_mem(0, 28'h10, '0);
        do_req(32'h104, 0, 0, 4'h0, 0, 32'h1122CCDD);
        chk("hit_count_8", hit_count, 32'd8);
        chk("miss_count_4", miss_count, 32'd4);

        // Write miss allocates, merges, completes without the hit flag.
        expect_mem(0, 28'h50, '0);
        do_req(32'h500, 1, 32'h12345678, 4'hF, 0, 32'h0);
        do_req(32'h500, 0, 0, 4'h0, 1, 32'h12345678);

        // Request withdrawn mid-miss: refill still lands, no completion is reported.
        hold_resp = 1;
        expect_mem(0, 28'h61, '0);
        @(posedge clk); #1;
        addr = 32'h610; mem_rw = 1'b0; is_input_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1 is_input_valid = 1'b0;
        hold_resp = 0;
        repeat (5) @(posedge clk);
        #1 chk("withdrawn_is_ready", is_ready, 1'b1);
        do_req(32'h610, 0, 0, 4'h0, 1, 32'hC0DE0184);
        chk("hit_count_10", hit_count, 32'd10);
        chk("miss_count_6", miss_count, 32'd6);

        // Asynchronous reset during FILL_WAIT; the late response must be ignored.
        hold_resp = 1;
        expect_mem(0, 28'h41, '0);
        @(posedge clk); #1;
        addr = 32'h410; mem_rw = 1'b0; is_input_valid = 1'b1;
        start = accepted;
        for (int i = 0; i < 50 && accepted == start; i++) @(posedge clk);
        chk("fill_accepted", accepted - start, 1);
        #3 reset = 1'b0;
        #1;
        chk("async_is_ready", is_ready, 1'b1);
        chk("async_mem_req_valid", mem_req_valid, 1'b0);
        chk("async_out_valid", is_output_valid, 1'b0);
        chk("async_is_hit", is_hit, 1'b0);
        chk("async_dout", dout, 32'd0);
        chk("async_counts", {hit_count, miss_count}, 64'd0);
        is_input_valid = 1'b0;
        @(negedge clk); #1 reset = 1'b1;
        hold_resp = 0;
        repeat (4) @(posedge clk);
        expect_mem(0, 28'h41, '0);
        do_req(32'h410, 0, 0, 4'h0, 0, 32'hC0DE0104);
        chk("post_reset_miss_count", miss_count, 32'd1);
        chk("post_reset_hit_count", hit_count, 32'd0);

        repeat (3) @(posedge clk);
        chk("out_queue_drained", out_q.size(), 0);
        chk("mem_queue_drained", mem_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
